fdiv_iter: RTL and testbench

- Iterative single-precision floating-point divider, y = x1 / x2. It is the inverse operation of the pipelined multiplier in the FPU.
- Uses a radix-2 restoring mantissa division, one quotient bit per cycle, behind a valid/ready handshake.
- Shares the multiplier's numeric conventions: denormals are flushed to zero, rounding is round-half-up, and NaN is not handled.
- Sits in the FPU next to fmul and is issued by the FPU dispatch logic.

---
 rtl/fdiv_iter.sv | 148 ++++++++++++++
 tb/tb_fdiv_iter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fdiv_iter.sv
// Iterative single-precision divider, y = x1 / x2: one restoring quotient bit per
// cycle, denormals flushed to zero, round-half-up, no NaN/inf decoding on inputs.
module fdiv_iter (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] NORM  = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] ROUND = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [4:0] LAST_ITER = 5'd24;

    logic [2:0]         state;
    logic [4:0]         cnt;

    logic               sgn;
    logic [7:0]         e1;
    logic [7:0]         e2;
    logic [22:0]        m1;
    logic [22:0]        m2;
    logic [25:0]        rem;
    logic [24:0]        q;
    logic signed [9:0]  adj;

    logic               accept;
    logic [25:0]        dvs;
    logic               rem_ge;
    logic [24:0]        mant;
    logic               unused_hidden;
    logic signed [9:0]  exp_res;
    logic [31:0]        y_next;

    // Quotient q is 1.xxx with 24 fraction bits; keep 23 and add the guard bit.
    function automatic logic [24:0] round_half_up(input logic [24:0] qv);
        return {1'b0, qv[24:1]} + {24'd0, qv[0]};
    endfunction

    function automatic logic [31:0] pack_result(
        input logic              s,
        input logic [7:0]        ea,
        input logic [7:0]        eb,
        input logic signed [9:0] e,
        input logic [22:0]       frac
    );
        logic [31:0] r;
        if (eb == 8'd0)
            r = {s, 8'hFF, 23'd0};
        else if (ea == 8'd0)
            r = {s, 31'd0};
        else if (e <= 10'sd0)
            r = {s, 31'd0};
        else if (e >= 10'sd255)
            r = {s, 8'hFF, 23'd0};
        else
            r = {s, e[7:0], frac};
        return r;
    endfunction

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign dvs    = {2'b00, 1'b1, m2};
    assign rem_ge = (rem >= dvs);

    // A rounding carry leaves the sum at exactly 2^24, so the low 23 bits are already zero.
    assign mant          = round_half_up(q);
    assign unused_hidden = mant[23];
    assign exp_res       = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127
                           + adj + $signed({9'd0, mant[24]});
    assign y_next        = pack_result(sgn, e1, e2, exp_res, mant[22:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= 5'd0;
            y     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept)
                        state <= NORM;
                end
                NORM: begin
                    cnt   <= 5'd0;
                    state <= DIV;
                end
                DIV: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_ITER)
                        state <= ROUND;
                end
                ROUND: begin
                    y     <= y_next;
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    sgn <= x1[31] ^ x2[31];
                    e1  <= x1[30:23];
                    e2  <= x2[30:23];
                    m1  <= x1[22:0];
                    m2  <= x2[22:0];
                end
            end
            NORM: begin
                q <= 25'd0;
                if ({1'b1, m1} < {1'b1, m2}) begin
                    rem <= {1'b0, 1'b1, m1, 1'b0};
                    adj <= -10'sd1;
                end else begin
                    rem <= {2'b00, 1'b1, m1};
                    adj <= 10'sd0;
                end
            end
            DIV: begin
                if (rem_ge)
                    rem <= (rem - dvs) << 1;
                else
                    rem <= rem << 1;
                q <= {q[23:0], rem_ge};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fdiv_iter.sv
// Directed bench for fdiv_iter: table of operand/result vectors plus handshake
// backpressure and mid-operation reset sequences.
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] x1 = 32'd0;
    logic [31:0] x2 = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[19];

    fdiv_iter dut (
        .clk       (clk),
        .rstn      (rstn),
        .x1        (x1),
        .x2        (x2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Issue one op, scramble the inputs after the accepting edge, and wait for out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string name,
                          output logic [31:0] res);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        x1 = a;
        x2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x1 = $urandom;
        x2 = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 60) begin
            if (in_ready)
                busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, lat, 27);
        check({name, " in_ready low while busy"}, {31'd0, busy_ok}, 32'd1);
        check({name, " in_ready in DONE"}, {31'd0, in_ready}, 32'd0);
        res = y;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        logic        hold_ok;
        logic        quiet_ok;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB};
        vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000};
        vecs[3]  = '{32'h80000000, 32'h40000000, 32'h80000000};
        vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7F800000};
        vecs[5]  = '{32'h00800000, 32'h40000000, 32'h00000000};
        vecs[6]  = '{32'h7F000000, 32'h3F000000, 32'h7F800000};
        vecs[7]  = '{32'hBFC00000, 32'h3F000000, 32'hC0400000};
        vecs[8]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
        vecs[9]  = '{32'h3F800000, 32'h40000000, 32'h3F000000};
        vecs[10] = '{32'hC0800000, 32'hC0000000, 32'h40000000};
        vecs[11] = '{32'h40000000, 32'h40400000, 32'h3F2AAAAB};
        vecs[12] = '{32'h3F800000, 32'h80000000, 32'hFF800000};
        vecs[13] = '{32'h00400000, 32'h3F800000, 32'h00000000};
        vecs[14] = '{32'h7F000000, 32'h00800000, 32'h7F800000};
        vecs[15] = '{32'h00800000, 32'h7F000000, 32'h00000000};
        vecs[16] = '{32'h7F800000, 32'h40000000, 32'h7F000000};
        vecs[17] = '{32'h40A00000, 32'h40800000, 32'h3FA00000};
        vecs[18] = '{32'h80000000, 32'h80000000, 32'h7F800000};

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset y", y, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run_op(vecs[i].a, vecs[i].b, $sformatf("v%0d", i), res);
            check($sformatf("v%0d y", i), res, vecs[i].exp);
            @(posedge clk);
            #1;
            check($sformatf("v%0d drain out_valid", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("v%0d drain in_ready", i), {31'd0, in_ready}, 32'd1);
        end

        // Backpressure: result must hold while the consumer stalls.
        @(negedge clk);
        out_ready = 1'b0;
        run_op(32'hBFC00000, 32'h3F000000, "bp", res);
        check("bp y", res, 32'hC0400000);
        held = y;
        hold_ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (y !== held || !out_valid || in_ready)
                hold_ok = 1'b0;
        end
        check("bp hold stable", {31'd0, hold_ok}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", {31'd0, out_valid}, 32'd0);
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);
        run_op(32'h3F800000, 32'h40400000, "b2b", res);
        check("b2b y", res, 32'h3EAAAAAB);
        @(posedge clk);
        #1;

        // Reset in the middle of the DIV iterations.
        @(negedge clk);
        x1 = 32'h40C00000;
        x2 = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        check("pre-reset in_ready", {31'd0, in_ready}, 32'd0);
        rstn = 1'b0;
        #1;
        check("midreset out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset in_ready", {31'd0, in_ready}, 32'd1);
        check("midreset y", y, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        quiet_ok = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid)
                quiet_ok = 1'b0;
        end
        check("midreset no output", {31'd0, quiet_ok}, 32'd1);
        run_op(32'h40A00000, 32'h40800000, "post-reset", res);
        check("post-reset y", res, 32'h3FA00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
